// File: rtl/z_calculator_serial.sv
// rtl/z_calculator_serial.sv - serial Z(x) error-evaluator calculator over GF(2^M) (optional ZCALC_SIGMA_DEG_EN)
module z_calculator_serial #(
   parameter int          M         = 8,
   parameter int          T         = 8,
   parameter int unsigned PRIM_POLY = 32'h11D
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [T*M-1:0]       Sigma_flat,
   input  logic [T*M-1:0]       S_flat,
   output logic                 Busy,
   output logic                 Done,
`ifdef ZCALC_SIGMA_DEG_EN
   output logic [$clog2(T+1)-1:0] Sigma_Deg,
   output logic                 Deg_Err,
`endif
   output logic [T*M-1:0]       Zed_flat
);

   localparam int          IW      = $clog2(T+1);
   localparam logic [M-1:0] POLY_LO = M'(PRIM_POLY);

   // The STORE step is folded into the last INIT/MAC cycle of each coefficient,
   // so it has no state of its own.
   typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_MAC, ST_FIN} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [T*M-1:0]  r_sig;
   logic [T*M-1:0]  r_s;
   logic [T*M-1:0]  r_zbuf;
   logic [T*M-1:0]  r_zed;
   logic [IW-1:0]   r_i;
   logic [IW-1:0]   r_j;
   logic [M-1:0]    r_acc;
   logic            r_done;

   logic [IW-1:0]   w_ij;
   logic [M-1:0]    w_sig_i;
   logic [M-1:0]    w_s_i;
   logic [M-1:0]    w_sig_j;
   logic [M-1:0]    w_s_ij;
   logic [M-1:0]    w_init_val;
   logic [M-1:0]    w_mac_val;
   logic [M-1:0]    w_store_val;
   logic            w_store;
   logic            w_busy;
   logic            w_last_i;

   // Shift-and-reduce GF(2^M) multiply, fully unrolled over the M bits of b.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] x;
      p = '0;
      x = a;
      for (int n = 0; n < M; n++) begin
         if (b[n]) p = p ^ x;
         x = x[M-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
      end
      return p;
   endfunction

   assign w_ij       = r_i - r_j;
   assign w_last_i   = (r_i == IW'(T));
   assign w_init_val = w_s_i ^ w_sig_i;
   assign w_mac_val  = r_acc ^ gf_mul(w_sig_j, w_s_ij);

   // Operand selection from the latched sigma/syndrome vectors by the i and j counters.
   always_comb begin
      w_sig_i = '0;
      w_s_i   = '0;
      w_sig_j = '0;
      w_s_ij  = '0;
      for (int k = 1; k <= T; k++) begin
         if (r_i == IW'(k)) begin
            w_sig_i = r_sig[(k-1)*M +: M];
            w_s_i   = r_s[(k-1)*M +: M];
         end
         if (r_j == IW'(k)) w_sig_j = r_sig[(k-1)*M +: M];
         if (w_ij == IW'(k)) w_s_ij = r_s[(k-1)*M +: M];
      end
   end

   // Next-state logic plus Busy and the merged store strobe.
   always_comb begin
      w_next      = r_state;
      w_busy      = 1'b0;
      w_store     = 1'b0;
      w_store_val = w_init_val;
      case (r_state)
         ST_IDLE: begin
            if (Start) w_next = ST_INIT;
         end
         ST_INIT: begin
            w_busy = 1'b1;
            if (r_i == IW'(1)) begin
               w_store = 1'b1;
               w_next  = w_last_i ? ST_FIN : ST_INIT;
            end else begin
               w_next = ST_MAC;
            end
         end
         ST_MAC: begin
            w_busy      = 1'b1;
            w_store_val = w_mac_val;
            if (r_j == r_i - IW'(1)) begin
               w_store = 1'b1;
               w_next  = w_last_i ? ST_FIN : ST_INIT;
            end
         end
         ST_FIN: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

`ifdef ZCALC_SIGMA_DEG_EN
   logic [IW-1:0] w_deg;
   logic [IW-1:0] r_deg;
   logic          r_deg_err;

   // Highest non-zero sigma index of the latched job; later k overrides earlier.
   always_comb begin
      w_deg = '0;
      for (int k = 1; k <= T; k++) begin
         if (r_sig[(k-1)*M +: M] != '0) w_deg = IW'(k);
      end
   end

   // Degree and uncorrectable flag publish together with Zed_flat.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_deg     <= '0;
         r_deg_err <= 1'b0;
      end else if (r_state == ST_FIN) begin
         r_deg     <= w_deg;
         r_deg_err <= (w_deg == '0) && (r_s != '0);
      end
   end

   assign Sigma_Deg = r_deg;
   assign Deg_Err   = r_deg_err;
`endif

   // Datapath: input latch, accumulator, counters, z buffer and published result.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_sig  <= '0;
         r_s    <= '0;
         r_zbuf <= '0;
         r_zed  <= '0;
         r_i    <= '0;
         r_j    <= '0;
         r_acc  <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_sig <= Sigma_flat;
                  r_s   <= S_flat;
                  r_i   <= IW'(1);
               end
            end
            ST_INIT: begin
               r_acc <= w_init_val;
               r_j   <= IW'(1);
            end
            ST_MAC: begin
               r_acc <= w_mac_val;
               r_j   <= r_j + IW'(1);
            end
            ST_FIN: begin
               r_zed  <= r_zbuf;
               r_done <= 1'b1;
            end
            default: begin
            end
         endcase
         if (w_store) begin
            for (int k = 1; k <= T; k++) begin
               if (r_i == IW'(k)) r_zbuf[(k-1)*M +: M] <= w_store_val;
            end
            if (!w_last_i) r_i <= r_i + IW'(1);
         end
      end
   end

   assign Busy     = w_busy;
   assign Done     = r_done;
   assign Zed_flat = r_zed;

endmodule

// File: tb/tb_z_calculator_serial.sv
// tb/tb_z_calculator_serial.sv - randomized self-checking bench for z_calculator_serial
module tb_z_calculator_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start4, start1;
   logic [63:0] sig8, s8, zed8;
   logic [31:0] sig4, s4, zed4;
   logic [7:0]  sig1, s1, zed1;
   logic        busy8, done8, busy4, done4, busy1, done1;
`ifdef ZCALC_SIGMA_DEG_EN
   logic [3:0]  deg8;
   logic [2:0]  deg4;
   logic [0:0]  deg1;
   logic        err8, err4, err1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   z_calculator_serial #(.M(8), .T(8), .PRIM_POLY(32'h11D)) dut8 (
      .Clk(clk), .Reset(rst), .Start(start8), .Sigma_flat(sig8), .S_flat(s8),
      .Busy(busy8), .Done(done8),
`ifdef ZCALC_SIGMA_DEG_EN
      .Sigma_Deg(deg8), .Deg_Err(err8),
`endif
      .Zed_flat(zed8));

   z_calculator_serial #(.M(8), .T(4), .PRIM_POLY(32'h11D)) dut4 (
      .Clk(clk), .Reset(rst), .Start(start4), .Sigma_flat(sig4), .S_flat(s4),
      .Busy(busy4), .Done(done4),
`ifdef ZCALC_SIGMA_DEG_EN
      .Sigma_Deg(deg4), .Deg_Err(err4),
`endif
      .Zed_flat(zed4));

   z_calculator_serial #(.M(8), .T(1), .PRIM_POLY(32'h11D)) dut1 (
      .Clk(clk), .Reset(rst), .Start(start1), .Sigma_flat(sig1), .S_flat(s1),
      .Busy(busy1), .Done(done1),
`ifdef ZCALC_SIGMA_DEG_EN
      .Sigma_Deg(deg1), .Deg_Err(err1),
`endif
      .Zed_flat(zed1));

   // Reference: full carry-less product, then polynomial long division by 0x11D.
   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      logic [14:0] poly;
      prod = '0;
      for (int n = 0; n < 8; n++) if (b[n]) prod = prod ^ (15'(a) << n);
      for (int bit_i = 14; bit_i >= 8; bit_i--) begin
         poly = 15'h11D << (bit_i - 8);
         if (prod[bit_i]) prod = prod ^ poly;
      end
      return prod[7:0];
   endfunction

   // z_k = S_k + sigma_k + sum_{j=1..k-1} sigma_j * S_{k-j}
   function automatic logic [7:0] ref_z(input logic [63:0] sg, input logic [63:0] ss, input int k);
      logic [7:0] z;
      z = ss[(k-1)*8 +: 8] ^ sg[(k-1)*8 +: 8];
      for (int j = 1; j < k; j++) z = z ^ ref_mul(sg[(j-1)*8 +: 8], ss[(k-j-1)*8 +: 8]);
      return z;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one T=8 job; optionally re-pulses Start at sample n==repulse_at.
   task automatic run8(input logic [63:0] sg, input logic [63:0] ss, input int repulse_at,
                       output int lat, output int bcnt, output logic stable);
      logic [63:0] z_before;
      z_before = zed8;
      sig8 = sg; s8 = ss; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      sig8 = {$urandom, $urandom};
      s8   = {$urandom, $urandom};
      lat = -1; bcnt = 0; stable = 1'b1;
      for (int n = 0; n < 80; n++) begin
         if (busy8) bcnt++;
         start8 = (n == repulse_at);
         tick;
         if (done8) begin
            lat = n + 1;
            break;
         end
         if (zed8 !== z_before) stable = 1'b0;
      end
      start8 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy8); end
      total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done8); end
      total++; if (zed8 !== 64'h0) begin bad++; $display("FAIL reset_zed got %h want 0", zed8); end
      total++; if (busy4 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy_small got %b%b want 00", busy4, busy1); end
      rst = 1'b0;
      tick;
   endtask

   task automatic test_counting;
      logic [63:0] ss;
      int lat, bcnt;
      logic stable;
      for (int k = 1; k <= 8; k++) ss[(k-1)*8 +: 8] = 8'(k);
      run8(64'h0, ss, -1, lat, bcnt, stable);
      total++; if (lat !== 37) begin bad++; $display("FAIL count_latency got %0d want 37", lat); end
      total++; if (bcnt !== 36) begin bad++; $display("FAIL count_busy got %0d want 36", bcnt); end
      total++; if (stable !== 1'b1) begin bad++; $display("FAIL count_zed_partial got %b want 1", stable); end
      for (int k = 1; k <= 8; k++) begin
         total++;
         if (zed8[(k-1)*8 +: 8] !== 8'(k)) begin
            bad++; $display("FAIL count_z%0d got %h want %h", k, zed8[(k-1)*8 +: 8], 8'(k));
         end
      end
      tick;
      total++; if (done8 !== 1'b0) begin bad++; $display("FAIL count_done_pulse got %b want 0", done8); end
   endtask

   task automatic test_single_term;
      int lat, bcnt;
      logic stable;
      run8(64'h0000_0000_0000_0080, 64'h0000_0000_0000_0002, -1, lat, bcnt, stable);
      total++; if (lat !== 37) begin bad++; $display("FAIL single_latency got %0d want 37", lat); end
      total++;
      if (zed8 !== 64'h0000_0000_0000_1D82) begin
         bad++; $display("FAIL single_zed got %h want 0000000000001d82", zed8);
      end
   endtask

   task automatic test_golden;
      logic [7:0] sl [8] = '{8'd249, 8'd49, 8'd237, 8'd55, 8'd207, 8'd139, 8'd86, 8'd88};
      logic [7:0] syl[8] = '{8'd229, 8'd104, 8'd56, 8'd157, 8'd207, 8'd241, 8'd179, 8'd29};
      logic [63:0] sg, ss;
      int lat, bcnt, extra;
      logic stable;
      for (int k = 0; k < 8; k++) begin
         sg[k*8 +: 8] = sl[k];
         ss[k*8 +: 8] = syl[k];
      end
      run8(sg, ss, 5, lat, bcnt, stable);
      total++; if (lat !== 37) begin bad++; $display("FAIL golden_latency got %0d want 37", lat); end
      for (int k = 1; k <= 8; k++) begin
         total++;
         if (zed8[(k-1)*8 +: 8] !== ref_z(sg, ss, k)) begin
            bad++; $display("FAIL golden_z%0d got %h want %h", k, zed8[(k-1)*8 +: 8], ref_z(sg, ss, k));
         end
      end
      extra = 0;
      repeat (45) begin
         tick;
         if (done8) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL golden_extra_done got %0d want 0", extra); end
   endtask

   task automatic test_random;
      logic [63:0] sg, ss;
      int lat, bcnt;
      logic stable;
      for (int it = 0; it < 8; it++) begin
         sg = {$urandom, $urandom};
         ss = {$urandom, $urandom};
         if (it == 0) sg[63:56] = 8'h00;
         run8(sg, ss, -1, lat, bcnt, stable);
         total++; if (lat !== 37) begin bad++; $display("FAIL rand%0d_latency got %0d want 37", it, lat); end
         for (int k = 1; k <= 8; k++) begin
            total++;
            if (zed8[(k-1)*8 +: 8] !== ref_z(sg, ss, k)) begin
               bad++; $display("FAIL rand%0d_z%0d got %h want %h", it, k, zed8[(k-1)*8 +: 8], ref_z(sg, ss, k));
            end
         end
      end
   endtask

   task automatic test_reset_abort;
      logic [63:0] sg, ss;
      int lat, bcnt, extra;
      logic stable;
      sg = {$urandom, $urandom};
      ss = {$urandom, $urandom} | 64'h1;
      sig8 = sg; s8 = ss; start8 = 1'b1;
      tick;
      start8 = 1'b0;
      repeat (19) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL abort_busy got %b want 0", busy8); end
      total++; if (zed8 !== 64'h0) begin bad++; $display("FAIL abort_zed got %h want 0", zed8); end
      extra = 0;
      repeat (50) begin
         if (done8) extra++;
         tick;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL abort_done got %0d want 0", extra); end
      run8(sg, ss, -1, lat, bcnt, stable);
      total++; if (lat !== 37) begin bad++; $display("FAIL abort_rerun_latency got %0d want 37", lat); end
      for (int k = 1; k <= 8; k++) begin
         total++;
         if (zed8[(k-1)*8 +: 8] !== ref_z(sg, ss, k)) begin
            bad++; $display("FAIL abort_rerun_z%0d got %h want %h", k, zed8[(k-1)*8 +: 8], ref_z(sg, ss, k));
         end
      end
   endtask

   task automatic test_back_to_back;
      int hits[$];
      logic [63:0] sg, ss;
      sg = {32'h0, $urandom};
      ss = {32'h0, $urandom};
      sig4 = sg[31:0]; s4 = ss[31:0]; start4 = 1'b1;
      tick;
      for (int n = 1; n <= 30; n++) begin
         tick;
         if (done4) hits.push_back(n);
      end
      start4 = 1'b0;
      repeat (30) tick;
      total++; if (hits.size() !== 2) begin bad++; $display("FAIL b2b_done_count got %0d want 2", hits.size()); end
      total++; if (hits.size() < 1 || hits[0] !== 11) begin bad++; $display("FAIL b2b_first_done got %0d want 11", (hits.size() > 0) ? hits[0] : -1); end
      total++; if (hits.size() < 2 || hits[1] !== 23) begin bad++; $display("FAIL b2b_second_done got %0d want 23", (hits.size() > 1) ? hits[1] : -1); end
      for (int k = 1; k <= 4; k++) begin
         total++;
         if (zed4[(k-1)*8 +: 8] !== ref_z(sg, ss, k)) begin
            bad++; $display("FAIL b2b_z%0d got %h want %h", k, zed4[(k-1)*8 +: 8], ref_z(sg, ss, k));
         end
      end
   endtask

   task automatic test_t1;
      int lat;
      logic [7:0] a, b;
      a = 8'($urandom); b = 8'($urandom) | 8'h01;
      sig1 = a; s1 = b; start1 = 1'b1;
      tick;
      start1 = 1'b0;
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         tick;
         if (done1) begin
            lat = n + 1;
            break;
         end
      end
      total++; if (lat !== 2) begin bad++; $display("FAIL t1_latency got %0d want 2", lat); end
      total++; if (zed1 !== (a ^ b)) begin bad++; $display("FAIL t1_z got %h want %h", zed1, a ^ b); end
      tick;
   endtask

`ifdef ZCALC_SIGMA_DEG_EN
   task automatic test_sigma_deg;
      int lat, bcnt;
      logic stable;
      run8(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0500, -1, lat, bcnt, stable);
      total++; if (deg8 !== 4'd3) begin bad++; $display("FAIL deg_a got %0d want 3", deg8); end
      total++; if (err8 !== 1'b0) begin bad++; $display("FAIL deg_err_a got %b want 0", err8); end
      run8(64'h0, 64'h0000_0000_0000_0007, -1, lat, bcnt, stable);
      total++; if (deg8 !== 4'd0) begin bad++; $display("FAIL deg_b got %0d want 0", deg8); end
      total++; if (err8 !== 1'b1) begin bad++; $display("FAIL deg_err_b got %b want 1", err8); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      start8 = 1'b0; start4 = 1'b0; start1 = 1'b0;
      sig8 = '0; s8 = '0; sig4 = '0; s4 = '0; sig1 = '0; s1 = '0;
      test_reset;
      test_counting;
      test_single_term;
      test_golden;
      test_random;
      test_reset_abort;
      test_back_to_back;
      test_t1;
`ifdef ZCALC_SIGMA_DEG_EN
      test_sigma_deg;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/z_calculator_serial.md
Name: z_calculator_serial

Overview:
- Parametrised, resource-shared successor to the fixed t=8 Z-polynomial calculator in the Reed-Solomon decoder.
- Computes the error-evaluator coefficients z_1..z_T of Z(x) = 1 + z_1x + ... + z_Tx^T over GF(2^M):
  z_i = S_i + sigma_i + sum_{j=1..i-1} sigma_j*S_{i-j}
- Sits between the Berlekamp-Massey sigma solver and the Chien/Forney stage.
- Uses a single GF multiplier-accumulator with a Start/Done handshake, instead of a fully parallel array.

Parameters:
- M, 8, symbol width in bits (GF(2^M)).
- T, 8, error-correction capability; number of z coefficients produced.
- PRIM_POLY, 9'h11D, field generator polynomial including the x^M term (DVB-T default).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE.
- Sigma_flat  in  T*M  sigma_k at bits [k*M-1:(k-1)*M], k=1..T.
- S_flat  in  T*M  syndrome S_k at bits [k*M-1:(k-1)*M], k=1..T.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse; Zed_flat is valid from this cycle onward.
- Zed_flat  out  T*M  z_k at bits [k*M-1:(k-1)*M]; held until the next Done.

Behaviour:
- Reset (synchronous, active-high; also when asserted mid-operation):
  - State returns to IDLE.
  - Busy=0, Done=0, Zed_flat=0, internal accumulator and counters cleared.
  - No Done is issued for an aborted job.
- States: IDLE, INIT, MAC, STORE, FIN.
- IDLE:
  - On Start=1 at edge E0, Sigma_flat and S_flat are latched into internal registers, i is set to 1, and the next state is INIT.
  - Input changes after E0 have no effect on the running job.
- INIT: acc <= S_i XOR sigma_i; j <= 1. Next state is MAC if i>1, else STORE.
- MAC: acc <= acc XOR gfmul(sigma_j, S_{i-j}); j <= j+1. Stays in MAC while j<i-1, then goes to STORE.
- STORE:
  - acc is written to internal z buffer slot i.
  - If i==T, next state is FIN; otherwise i <= i+1 and next state is INIT.
  - STORE is merged into the last INIT/MAC cycle, so coefficient i costs exactly i cycles.
- FIN:
  - The z buffer is copied to Zed_flat and Done=1 for one cycle.
  - Next state is IDLE, and Busy drops in the same cycle.
- Latency:
  - Done is asserted in cycle E0 + T(T+1)/2 + 1: 37 cycles for T=8, 11 for T=4.
  - Busy is high for T(T+1)/2 cycles.
- gfmul: combinational shift-and-reduce modulo PRIM_POLY, M iterations unrolled. Multiplying by 0 yields 0.
- Addition is bitwise XOR; no carries; all values stay M bits wide.
- Start while Busy=1 or in the FIN cycle is ignored (not queued).
- Start held high continuously: a new job is accepted on the first IDLE cycle after FIN, i.e. back-to-back jobs have a one-cycle gap.
- Zed_flat changes only in the FIN cycle; it never shows partial results.
- T=1 is legal: INIT then FIN, with Done at E0+2.

Optional Feature:
- Macro: ZCALC_SIGMA_DEG_EN.
- When defined:
  - Adds output Sigma_Deg, width $clog2(T+1), set to the highest k with sigma_k != 0 (0 if all zero). Updated in the FIN cycle with Zed_flat; reset value 0.
  - Adds output Deg_Err, 1 bit, set when Sigma_Deg is 0 but any S_k != 0 (uncorrectable flag). Updated in the FIN cycle; reset value 0.
- When undefined: neither port exists and no degree logic is generated. Latency and all other behaviour are identical in both builds.

Test Plan:
1. T=8; Sigma=0; S_k=k (1..8); pulse Start -> Zed z_k=k (k=1..8); Done exactly 37 cycles after the Start edge; Busy high for 36 cycles.
2. T=8; sigma_1=8'h80, other sigma=0; S_1=8'h02, other S=0 -> z_1=8'h82, z_2=8'h1D, z_3..z_8=0.
3. T=8; Sigma={249,49,237,55,207,139,86,88}; S1..S8={229,104,56,157,207,241,179,29} -> Zed matches the bit-exact software golden model; Start re-pulsed while Busy produces no extra Done.
4. Reset asserted at cycle 20 of a job -> next cycle Busy=0, Zed_flat=0; no Done appears; a subsequent Start completes normally in 37 cycles.
5. T=4 build; Start held high for 30 cycles -> Done pulses at E0+11, then at E0+23 (one-cycle IDLE gap between jobs).
6. ZCALC_SIGMA_DEG_EN defined; sigma_3=1, all others 0; S_2=5 -> Sigma_Deg=3, Deg_Err=0. Then Sigma=0, S_1=7 -> Sigma_Deg=0, Deg_Err=1.
